// File: rtl/branch_ctrl_if.sv
// Decoder/ALU/button to PC-control bus; master drives instruction decode, slave drives PC control.
interface branch_ctrl_if #(
  parameter int unsigned AddrSz = 6
);
  logic              br_eq;
  logic              br_ne;
  logic              jmp;
  logic              wait_btn;
  logic [AddrSz-1:0] imm;
  logic              alu_zero;
  logic              flag_we;
  logic              btn;
  logic              rel_branch;
  logic [AddrSz-1:0] offset;
  logic              stalled;
  logic              z_flag;

  modport master (
    output br_eq, br_ne, jmp, wait_btn, imm, alu_zero, flag_we, btn,
    input  rel_branch, offset, stalled, z_flag
  );

  modport slave (
    input  br_eq, br_ne, jmp, wait_btn, imm, alu_zero, flag_we, btn,
    output rel_branch, offset, stalled, z_flag
  );
endinterface

// File: rtl/branch_ctrl.sv
// Branch/jump/wait control for the program counter, with registered Z flag
// and a synchronised, debounced push button gating the WAIT instruction.
module branch_ctrl #(
  parameter int unsigned AddrSz         = 6,
  parameter int unsigned DebounceCycles = 4
) (
  input  logic           clk,
  input  logic           n_reset,
  branch_ctrl_if.slave   bus
);

  localparam int unsigned CntW = $clog2(DebounceCycles + 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    WAIT_RELEASE = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_z_flag;
  logic              r_sync1;
  logic              r_btn_s;
  logic              r_btn_db;
  logic [CntW-1:0]   r_cnt;

  logic              w_release;
  logic              w_rel_branch;
  logic [AddrSz-1:0] w_offset;
  logic              w_stalled;

  // Zero flag: updated only by flag-writing instructions; branches see the old value.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) r_z_flag <= 1'b0;
    else if (bus.flag_we) r_z_flag <= bus.alu_zero;
  end

  // Two-flop synchroniser for the raw button.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_sync1 <= 1'b0;
      r_btn_s <= 1'b0;
    end else begin
      r_sync1 <= bus.btn;
      r_btn_s <= r_sync1;
    end
  end

  // Debounce: debounced level flips only after a sustained disagreement.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_btn_db <= 1'b0;
      r_cnt    <= '0;
    end else if (r_btn_s == r_btn_db) begin
      r_cnt    <= '0;
    end else if (r_cnt == CntW'(DebounceCycles - 1)) begin
      r_btn_db <= r_btn_s;
      r_cnt    <= '0;
    end else begin
      r_cnt    <= r_cnt + CntW'(1);
    end
  end

  // Wait FSM: one full press-and-release releases one WAIT.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE:         if (bus.wait_btn) r_state <= WAIT_PRESS;
        WAIT_PRESS:   if (!bus.wait_btn) r_state <= IDLE;
                      else if (r_btn_db) r_state <= WAIT_RELEASE;
        WAIT_RELEASE: if (!bus.wait_btn || !r_btn_db) r_state <= IDLE;
        default:      r_state <= IDLE;
      endcase
    end
  end

  assign w_release = (r_state == WAIT_RELEASE) && !r_btn_db;

  // PC control decode; priority wait_btn > jmp > br_eq > br_ne.
  always_comb begin
    w_rel_branch = 1'b0;
    w_offset     = '0;
    w_stalled    = 1'b0;
    if (bus.wait_btn) begin
      if (!w_release) begin
        w_rel_branch = 1'b1;
        w_stalled    = 1'b1;
      end
    end else if (bus.jmp) begin
      w_rel_branch = 1'b1;
      w_offset     = bus.imm;
    end else if ((bus.br_eq && r_z_flag) || (bus.br_ne && !r_z_flag)) begin
      w_rel_branch = 1'b1;
      w_offset     = bus.imm;
    end
  end

  assign bus.rel_branch = w_rel_branch;
  assign bus.offset     = w_offset;
  assign bus.stalled    = w_stalled;
  assign bus.z_flag     = r_z_flag;

endmodule

// File: tb/tb_branch_ctrl.sv
// Self-checking bench for branch_ctrl: vector table for branch/jump decode,
// hand sequences for WAIT, debounce, glitch rejection and reset mid-wait.
module tb_branch_ctrl;

  localparam int unsigned AddrSz = 6;

  typedef struct {
    logic              flag_we;
    logic              alu_zero;
    logic              br_eq;
    logic              br_ne;
    logic              jmp;
    logic [AddrSz-1:0] imm;
    logic              exp_rel;
    logic [AddrSz-1:0] exp_off;
    logic              exp_z;
  } vec_t;

  typedef struct {
    string             name;
    logic              rel;
    logic [AddrSz-1:0] off;
    logic              stall;
  } exp_t;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  logic [AddrSz-1:0] pc = '0;
  int n_cmp = 0;
  int n_fail = 0;
  exp_t sb[$];
  vec_t vecs[13];

  branch_ctrl_if #(.AddrSz(AddrSz)) bus();

  branch_ctrl #(.AddrSz(AddrSz), .DebounceCycles(4)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // Simple PC model fed by the DUT's control outputs.
  always @(posedge clk or negedge n_reset) begin
    if (!n_reset) pc <= '0;
    else pc <= bus.rel_branch ? pc + bus.offset : pc + 6'd1;
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input string name, input logic rel, input logic [AddrSz-1:0] off,
                          input logic stall);
    exp_t e;
    e.name = name; e.rel = rel; e.off = off; e.stall = stall;
    sb.push_back(e);
  endtask

  // Let combinational outputs settle, then pop and compare.
  task automatic check_out();
    exp_t e;
    #1;
    if (sb.size() == 0) begin
      cmp("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      cmp({e.name, ".rel_branch"}, 32'(bus.rel_branch), 32'(e.rel));
      cmp({e.name, ".offset"},     32'(bus.offset),     32'(e.off));
      cmp({e.name, ".stalled"},    32'(bus.stalled),    32'(e.stall));
    end
  endtask

  task automatic expect_out(input string name, input logic rel, input logic [AddrSz-1:0] off,
                            input logic stall);
    push_exp(name, rel, off, stall);
    check_out();
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.br_eq = 0; bus.br_ne = 0; bus.jmp = 0; bus.wait_btn = 0;
    bus.imm = '0; bus.alu_zero = 0; bus.flag_we = 0;
  endtask

  initial begin
    logic [AddrSz-1:0] pc_mark;
    logic [AddrSz-1:0] pc_calc;

    // {flag_we, alu_zero, br_eq, br_ne, jmp, imm, exp_rel, exp_off, exp_z}
    vecs[0]  = '{0, 0, 0, 0, 0, 6'h00, 0, 6'h00, 0};
    vecs[1]  = '{1, 1, 0, 0, 0, 6'h00, 0, 6'h00, 0};
    vecs[2]  = '{0, 0, 1, 0, 0, 6'h05, 1, 6'h05, 1};
    vecs[3]  = '{0, 0, 0, 1, 0, 6'h05, 0, 6'h00, 1};
    vecs[4]  = '{1, 0, 1, 0, 0, 6'h07, 1, 6'h07, 1};
    vecs[5]  = '{0, 0, 0, 0, 0, 6'h00, 0, 6'h00, 0};
    vecs[6]  = '{0, 0, 0, 1, 0, 6'h3E, 1, 6'h3E, 0};
    vecs[7]  = '{0, 0, 1, 0, 0, 6'h09, 0, 6'h00, 0};
    vecs[8]  = '{0, 0, 0, 1, 1, 6'h3E, 1, 6'h3E, 0};
    vecs[9]  = '{0, 0, 1, 0, 1, 6'h01, 1, 6'h01, 0};
    vecs[10] = '{1, 1, 0, 1, 0, 6'h04, 1, 6'h04, 0};
    vecs[11] = '{0, 0, 0, 1, 0, 6'h04, 0, 6'h00, 1};
    vecs[12] = '{0, 0, 0, 0, 1, 6'h20, 1, 6'h20, 1};

    clear_inputs();
    bus.btn = 0;
    #1;
    cmp("reset.z_flag", 32'(bus.z_flag), 32'd0);
    expect_out("reset", 0, 6'h00, 0);
    step(); step();
    n_reset = 1;

    // Branch/jump decode table.
    for (int i = 0; i < 13; i++) begin
      bus.flag_we = vecs[i].flag_we; bus.alu_zero = vecs[i].alu_zero;
      bus.br_eq = vecs[i].br_eq; bus.br_ne = vecs[i].br_ne;
      bus.jmp = vecs[i].jmp; bus.imm = vecs[i].imm;
      push_exp($sformatf("vec%0d", i), vecs[i].exp_rel, vecs[i].exp_off, 1'b0);
      check_out();
      cmp($sformatf("vec%0d.z_flag", i), 32'(bus.z_flag), 32'(vecs[i].exp_z));
      if (i == 8) begin
        pc_calc = 6'd2 + bus.offset;
        cmp("vec8.pc_wrap", 32'(pc_calc), 32'd0);
      end
      step();
    end
    clear_inputs();
    step();

    // WAIT with button low: PC held every cycle.
    bus.wait_btn = 1;
    pc_mark = pc;
    for (int i = 0; i < 20; i++) begin
      expect_out("wait_low", 1, 6'h00, 1);
      step();
    end
    cmp("wait_low.pc_held", 32'(pc), 32'(pc_mark));

    // Press: debounced level rises 6 edges after the input edge.
    bus.btn = 1;
    for (int k = 0; k < 10; k++) begin
      expect_out("wait_press", 1, 6'h00, 1);
      cmp($sformatf("press_db_k%0d", k), 32'(dut.r_btn_db), (k >= 6) ? 32'd1 : 32'd0);
      step();
    end

    // Release: exactly one non-stalled cycle 6 edges after the fall, then a fresh WAIT.
    bus.btn = 0;
    for (int k = 0; k < 10; k++) begin
      if (k == 6) begin
        expect_out("release", 0, 6'h00, 0);
        pc_mark = pc;
      end else begin
        expect_out($sformatf("release_k%0d", k), 1, 6'h00, 1);
      end
      if (k == 7) cmp("release.pc_advance", 32'(pc), 32'(pc_mark + 6'd1));
      step();
    end
    bus.wait_btn = 0;
    expect_out("wait_abort", 0, 6'h00, 0);
    step();
    cmp("wait_abort.state", 32'(dut.r_state), 32'd0);

    // Short glitch is rejected; stall persists.
    bus.wait_btn = 1;
    bus.btn = 1;
    step(); step();
    bus.btn = 0;
    for (int k = 0; k < 12; k++) begin
      expect_out("glitch", 1, 6'h00, 1);
      cmp("glitch.btn_db", 32'(dut.r_btn_db), 32'd0);
      step();
    end
    cmp("glitch.state", 32'(dut.r_state), 32'd1);
    bus.wait_btn = 0;
    step();

    // Set Z, hold button before WAIT, then reset in WAIT_RELEASE.
    bus.flag_we = 1; bus.alu_zero = 1;
    step();
    clear_inputs();
    cmp("preheld.z_set", 32'(bus.z_flag), 32'd1);
    bus.btn = 1;
    for (int k = 0; k < 8; k++) step();
    cmp("preheld.btn_db", 32'(dut.r_btn_db), 32'd1);
    bus.wait_btn = 1;
    for (int k = 0; k < 4; k++) begin
      expect_out("preheld", 1, 6'h00, 1);
      step();
    end
    cmp("preheld.state", 32'(dut.r_state), 32'd2);
    n_reset = 0;
    #1;
    cmp("rst_mid.z_flag", 32'(bus.z_flag), 32'd0);
    cmp("rst_mid.state",  32'(dut.r_state), 32'd0);
    cmp("rst_mid.btn_db", 32'(dut.r_btn_db), 32'd0);
    expect_out("rst_mid_wait", 1, 6'h00, 1);
    bus.wait_btn = 0;
    expect_out("rst_mid_idle", 0, 6'h00, 0);
    bus.btn = 0;
    step(); step();
    n_reset = 1;

    // After reset Z is clear: BEQ not taken, BNE taken.
    bus.br_eq = 1; bus.imm = 6'h05;
    expect_out("post_rst_beq", 0, 6'h00, 0);
    bus.br_eq = 0; bus.br_ne = 1;
    expect_out("post_rst_bne", 1, 6'h05, 0);
    step();
    clear_inputs();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
